// File: rtl/branch_predictor.sv
// branch_predictor -- IF-stage branch target buffer with per-entry saturating
// direction counters.
//
// The table is direct-mapped. It is indexed by pc[IDX_BITS+1:2] and tagged
// with the next TAG_BITS bits of the PC. A lookup is purely combinational. A
// training write lands at the rising edge, so a lookup in the same cycle still
// sees the old entry.
//
// Optional feature: define BRANCH_PREDICTOR_STATS_EN to build the 32-bit
// lookup and mispredict counters. When it is undefined, both counter outputs
// are tied to zero.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   pc_i                  fetch PC to look up
//   hit_o                 valid entry with a matching tag
//   pred_taken_o          predicted taken
//   pred_target_o         predicted next PC (stored target, or pc_i + 4)
//   upd_valid_i           strobe for a resolved branch or jump
//   upd_pc_i              PC of the resolved instruction
//   upd_taken_i           actual outcome
//   upd_target_i          actual taken target
//   upd_is_jump_i         unconditional jump (jal/jalr)
//   upd_mispredict_i      the resolver flagged a misprediction (statistics only)
//   flush_i               synchronous invalidate of all entries; wins over an update
//   lookup_cnt_o          lookups counted
//   mispredict_cnt_o      mispredictions counted
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int XLEN     = 32,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            hit_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_is_jump_i,
    input  logic            upd_mispredict_i,
    input  logic            flush_i,
    output logic [31:0]     lookup_cnt_o,
    output logic [31:0]     mispredict_cnt_o
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly taken: the MSB is set and every other bit is clear.
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [ENTRIES-1:0]  valid;
    logic [ENTRIES-1:0]  is_jump;
    logic [TAG_BITS-1:0] tag    [ENTRIES];
    logic [XLEN-1:0]     target [ENTRIES];
    logic [CTR_BITS-1:0] ctr    [ENTRIES];

    // Lookup path
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;

    assign lk_idx        = pc_i[IDX_BITS+1:2];
    assign lk_tag        = pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign hit_o         = valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign pred_taken_o  = hit_o && (is_jump[lk_idx] || ctr[lk_idx][CTR_BITS-1]);
    assign pred_target_o = pred_taken_o ? target[lk_idx] : pc_i + XLEN'(4);

    // Update path
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;

    assign u_idx = upd_pc_i[IDX_BITS+1:2];
    assign u_tag = upd_pc_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid   <= '0;
            is_jump <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= '0;
            end
        end else if (flush_i) begin
            // Only the valid bits are cleared. Counters and targets stay as
            // they are, and a simultaneous update is dropped.
            valid <= '0;
        end else if (upd_valid_i) begin
            if (u_hit) begin
                if (upd_is_jump_i) begin
                    ctr[u_idx]     <= CTR_MAX;
                    target[u_idx]  <= upd_target_i;
                    is_jump[u_idx] <= 1'b1;
                end else if (upd_taken_i) begin
                    if (ctr[u_idx] != CTR_MAX) ctr[u_idx] <= ctr[u_idx] + 1'b1;
                    target[u_idx] <= upd_target_i;
                end else begin
                    // A conditional update on an entry already marked as a
                    // jump moves the counter but keeps is_jump set.
                    if (ctr[u_idx] != '0) ctr[u_idx] <= ctr[u_idx] - 1'b1;
                end
            end else if (upd_taken_i) begin
                // Allocate on a taken miss and evict whatever was at the index.
                valid[u_idx]   <= 1'b1;
                tag[u_idx]     <= u_tag;
                target[u_idx]  <= upd_target_i;
                is_jump[u_idx] <= upd_is_jump_i;
                ctr[u_idx]     <= upd_is_jump_i ? CTR_MAX : CTR_WEAK;
            end
        end
    end

    // Only some PC bits form the index and tag, and the mispredict flag is
    // used only by the statistics build.
    logic unused_ok;
    assign unused_ok = ^{upd_pc_i, upd_mispredict_i};

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] lookup_cnt;
    logic [31:0] mispredict_cnt;

    // Both counters wrap naturally, and flush_i does not clear them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lookup_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            lookup_cnt <= lookup_cnt + 32'd1;
            if (upd_valid_i && upd_mispredict_i)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign lookup_cnt_o     = lookup_cnt;
    assign mispredict_cnt_o = mispredict_cnt;
`else
    assign lookup_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor with the default parameters
// (ENTRIES=16, XLEN=32, TAG_BITS=8, CTR_BITS=2). Inputs are driven on the
// falling edge, and the combinational outputs are sampled 1 ns later.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_is_jump = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] lookup_cnt, mispredict_cnt;

    int vectors = 0;
    int errors  = 0;

    branch_predictor dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc),
        .hit_o(hit), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .upd_is_jump_i(upd_is_jump),
        .upd_mispredict_i(upd_mispredict), .flush_i(flush),
        .lookup_cnt_o(lookup_cnt), .mispredict_cnt_o(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Drive a PC, let the combinational path settle, and check all three
    // lookup outputs.
    task automatic look(input string name, input logic [31:0] p, input logic eh,
                        input logic et, input logic [31:0] etgt);
        pc = p;
        #1;
        chk({name, ".hit"}, {31'd0, hit}, {31'd0, eh});
        chk({name, ".taken"}, {31'd0, pred_taken}, {31'd0, et});
        chk({name, ".target"}, pred_target, etgt);
    endtask

    // Apply one update for one clock edge. Call it from a falling edge; it
    // returns on the next falling edge.
    task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                       input logic j);
        upd_valid = 1'b1; upd_pc = p; upd_taken = t; upd_target = tgt; upd_is_jump = j;
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0; upd_taken = 1'b0; upd_is_jump = 1'b0;
    endtask

    initial begin
        // Check the outputs while reset is held.
        look("rst", 32'h100, 0, 0, 32'h104);
        chk("rst.lcnt", lookup_cnt, 32'd0);
        chk("rst.mcnt", mispredict_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        look("cold", 32'h100, 0, 0, 32'h104);

        // Allocate 0x100 -> 0x40. A lookup in the same cycle still sees the
        // old contents.
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h40;
        look("same_cyc", 32'h100, 0, 0, 32'h104);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0; upd_taken = 1'b0;
        look("alloc", 32'h100, 1, 1, 32'h40);

        // Counter sequence 2 -> 1 -> 0.
        upd(32'h100, 0, 32'h0, 0);
        look("ctr1", 32'h100, 1, 0, 32'h104);
        upd(32'h100, 0, 32'h0, 0);
        look("ctr0", 32'h100, 1, 0, 32'h104);
        // Four taken updates: 0 -> 1 -> 2 -> 3 -> 3 (the last one clamps).
        for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h40, 0);
        look("ctr3", 32'h100, 1, 1, 32'h40);
        upd(32'h100, 0, 32'h0, 0);
        look("sat_dn2", 32'h100, 1, 1, 32'h40);
        upd(32'h100, 0, 32'h0, 0);
        look("sat_dn1", 32'h100, 1, 0, 32'h104);

        // Conflict at index 0: 0x140 evicts 0x100.
        upd(32'h140, 1, 32'h80, 0);
        look("evict_old", 32'h100, 0, 0, 32'h104);
        look("evict_new", 32'h140, 1, 1, 32'h80);
        // Not-taken updates that miss leave the table unchanged.
        upd(32'h180, 0, 32'h0, 0);
        upd(32'h100, 0, 32'h0, 0);
        look("nt_miss_a", 32'h140, 1, 1, 32'h80);
        look("nt_miss_b", 32'h180, 0, 0, 32'h184);

        // A jump keeps predicting taken after conditional not-taken updates
        // (ctr 3 -> 2 -> 1).
        upd(32'h200, 1, 32'h80, 1);
        look("jmp", 32'h200, 1, 1, 32'h80);
        upd(32'h200, 0, 32'h0, 0);
        look("jmp_nt1", 32'h200, 1, 1, 32'h80);
        upd(32'h200, 0, 32'h0, 0);
        look("jmp_nt2", 32'h200, 1, 1, 32'h80);

        // A second index; the low PC bits are ignored.
        upd(32'h104, 1, 32'h10, 0);
        look("idx1", 32'h106, 1, 1, 32'h10);

        // A flush with a simultaneous update drops the update.
        flush = 1'b1;
        upd(32'h300, 1, 32'h20, 0);
        flush = 1'b0;
        look("fl_a", 32'h200, 0, 0, 32'h204);
        look("fl_b", 32'h104, 0, 0, 32'h108);
        look("fl_c", 32'h300, 0, 0, 32'h304);

        // Reset asserted mid-cycle clears the table without waiting for a
        // clock edge.
        upd(32'h104, 1, 32'h10, 0);
        look("pre_rst", 32'h104, 1, 1, 32'h10);
        #2 rst = 1'b1;
        look("async_rst", 32'h104, 0, 0, 32'h108);
        chk("async_rst.lcnt", lookup_cnt, 32'd0);
        chk("async_rst.mcnt", mispredict_cnt, 32'd0);

        // Statistics: 10 edges out of reset, three of them with a mispredict
        // update. The update PC misses, so the table does not change.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            upd_valid = (i < 3); upd_mispredict = (i < 3); upd_pc = 32'h400;
            @(posedge clk);
            @(negedge clk);
        end
        upd_valid = 1'b0; upd_mispredict = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
        chk("stats.lcnt", lookup_cnt, 32'd10);
        chk("stats.mcnt", mispredict_cnt, 32'd3);
`else
        chk("stats.lcnt", lookup_cnt, 32'd0);
        chk("stats.mcnt", mispredict_cnt, 32'd0);
`endif
        look("post", 32'h400, 0, 0, 32'h404);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
